x1_mem_arbiter: RTL and testbench

//  Sequences the single port of the main system RAM (dpram port A) between three requesters:
//  - the ioctl download loader (write-only);
//  - the Z80 CPU bus (read/write, req/ack handshake);
//  - the video fetch unit (read-only).

---
 rtl/x1_mem_arbiter_if.sv | 54 +++++
 rtl/x1_mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_x1_mem_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/x1_mem_arbiter_if.sv
// rtl/x1_mem_arbiter_if.sv - requester and RAM port bundle for x1_mem_arbiter
interface x1_mem_arbiter_if #(
    parameter int AW = 16
);
    // ioctl download loader
    logic          ioctl_download;
    logic [7:0]    ioctl_index;
    logic          ioctl_wr;
    logic [24:0]   ioctl_addr;
    logic [7:0]    ioctl_dout;
    logic          ioctl_wait;
    logic          dl_busy;
    // Z80 CPU bus
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_din;
    logic [7:0]    cpu_dout;
    logic          cpu_ack;
    // video fetch unit
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic [7:0]    vid_dout;
    logic          vid_valid;
    // RAM port A
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [7:0]    ram_din;
    logic [7:0]    ram_dout;

    // Arbiter side
    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        output ioctl_wait, dl_busy,
        input  cpu_req, cpu_we, cpu_addr, cpu_din,
        output cpu_dout, cpu_ack,
        input  vid_req, vid_addr,
        output vid_dout, vid_valid,
        output ram_addr, ram_we, ram_din,
        input  ram_dout
    );

    // Requesters and RAM side
    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        input  ioctl_wait, dl_busy,
        output cpu_req, cpu_we, cpu_addr, cpu_din,
        input  cpu_dout, cpu_ack,
        output vid_req, vid_addr,
        input  vid_dout, vid_valid,
        input  ram_addr, ram_we, ram_din,
        output ram_dout
    );
endinterface

// File: rtl/x1_mem_arbiter.sv
// rtl/x1_mem_arbiter.sv - single-port RAM sequencer for download loader, CPU and video fetch
module x1_mem_arbiter #(
    parameter int          AW       = 16,
    parameter logic [7:0]  DL_INDEX = 8'h00
) (
    input  logic                clk_sys,
    input  logic                reset,
    x1_mem_arbiter_if.slave     bus
);
    logic          hold_valid_q, hold_valid_d;
    logic [AW-1:0] hold_addr_q,  hold_addr_d;
    logic [7:0]    hold_data_q,  hold_data_d;
    logic          dl_act_q,     dl_act_d;
    logic          vid_pend_q,   vid_pend_d;
    logic [AW-1:0] vid_addr_q,   vid_addr_d;
    logic          vid_last_q,   vid_last_d;
    logic          cpu_p1_q,     cpu_p1_d;
    logic          cpu_p1_we_q,  cpu_p1_we_d;
    logic          vid_p1_q,     vid_p1_d;
    logic          cpu_ack_q,    cpu_ack_d;
    logic [7:0]    cpu_dout_q,   cpu_dout_d;
    logic          vid_valid_q,  vid_valid_d;
    logic [7:0]    vid_dout_q,   vid_dout_d;
    logic [AW-1:0] last_addr_q,  last_addr_d;

    logic          dl_match, dl_in_range, dl_busy;
    logic          dl_elig, cpu_elig, vid_elig;
    logic          gnt_vid, gnt_dl, gnt_cpu;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [7:0]    ram_din;

    // Arbitration on registered pending state, RAM drive, and next-state for capture and return pipes
    always_comb begin
        dl_match    = bus.ioctl_download && (bus.ioctl_index == DL_INDEX);
        dl_in_range = (bus.ioctl_addr[24:AW] == '0);
        dl_busy     = dl_act_q || hold_valid_q;

        // CPU is blocked in G+1 so a held cpu_req is not re-granted before its ack
        dl_elig  = hold_valid_q;
        cpu_elig = bus.cpu_req && !dl_busy && !cpu_p1_q;
        // Video steps aside for one slot after a grant when anyone else is waiting
        vid_elig = vid_pend_q && !(vid_last_q && (dl_elig || cpu_elig));

        // Grants are suppressed while reset is held so the RAM sees no stray write
        gnt_vid = !reset && vid_elig;
        gnt_dl  = !reset && !vid_elig && dl_elig;
        gnt_cpu = !reset && !vid_elig && !dl_elig && cpu_elig;

        ram_addr = last_addr_q;
        ram_we   = 1'b0;
        ram_din  = 8'h00;
        if (gnt_vid) begin
            ram_addr = vid_addr_q;
        end else if (gnt_dl) begin
            ram_addr = hold_addr_q;
            ram_we   = 1'b1;
            ram_din  = hold_data_q;
        end else if (gnt_cpu) begin
            ram_addr = bus.cpu_addr;
            ram_we   = bus.cpu_we;
            ram_din  = bus.cpu_we ? bus.cpu_din : 8'h00;
        end
        last_addr_d = ram_addr;

        // A strobe arriving while the byte is still held is dropped, old byte kept
        hold_valid_d = hold_valid_q;
        hold_addr_d  = hold_addr_q;
        hold_data_d  = hold_data_q;
        if (gnt_dl) begin
            hold_valid_d = 1'b0;
        end else if (bus.ioctl_wr && dl_match && dl_in_range && !hold_valid_q) begin
            hold_valid_d = 1'b1;
            hold_addr_d  = bus.ioctl_addr[AW-1:0];
            hold_data_d  = bus.ioctl_dout;
        end
        dl_act_d = dl_match;

        // Latest video request wins; a request in the grant cycle keeps the flag set
        vid_pend_d = vid_pend_q && !gnt_vid;
        vid_addr_d = vid_addr_q;
        if (bus.vid_req) begin
            vid_pend_d = 1'b1;
            vid_addr_d = bus.vid_addr;
        end
        vid_last_d = gnt_vid;

        cpu_p1_d    = gnt_cpu;
        cpu_p1_we_d = gnt_cpu && bus.cpu_we;
        vid_p1_d    = gnt_vid;
        cpu_ack_d   = cpu_p1_q;
        vid_valid_d = vid_p1_q;
        cpu_dout_d  = (cpu_p1_q && !cpu_p1_we_q) ? bus.ram_dout : cpu_dout_q;
        vid_dout_d  = vid_p1_q ? bus.ram_dout : vid_dout_q;
    end

    // State registers; reset abandons any in-flight access
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            hold_valid_q <= 1'b0;
            hold_addr_q  <= '0;
            hold_data_q  <= 8'h00;
            dl_act_q     <= 1'b0;
            vid_pend_q   <= 1'b0;
            vid_addr_q   <= '0;
            vid_last_q   <= 1'b0;
            cpu_p1_q     <= 1'b0;
            cpu_p1_we_q  <= 1'b0;
            vid_p1_q     <= 1'b0;
            cpu_ack_q    <= 1'b0;
            cpu_dout_q   <= 8'h00;
            vid_valid_q  <= 1'b0;
            vid_dout_q   <= 8'h00;
            last_addr_q  <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_addr_q  <= hold_addr_d;
            hold_data_q  <= hold_data_d;
            dl_act_q     <= dl_act_d;
            vid_pend_q   <= vid_pend_d;
            vid_addr_q   <= vid_addr_d;
            vid_last_q   <= vid_last_d;
            cpu_p1_q     <= cpu_p1_d;
            cpu_p1_we_q  <= cpu_p1_we_d;
            vid_p1_q     <= vid_p1_d;
            cpu_ack_q    <= cpu_ack_d;
            cpu_dout_q   <= cpu_dout_d;
            vid_valid_q  <= vid_valid_d;
            vid_dout_q   <= vid_dout_d;
            last_addr_q  <= last_addr_d;
        end
    end

    assign bus.ioctl_wait = hold_valid_q;
    assign bus.dl_busy    = dl_busy;
    assign bus.cpu_ack    = cpu_ack_q;
    assign bus.cpu_dout   = cpu_dout_q;
    assign bus.vid_valid  = vid_valid_q;
    assign bus.vid_dout   = vid_dout_q;
    assign bus.ram_addr   = ram_addr;
    assign bus.ram_we     = ram_we;
    assign bus.ram_din    = ram_din;
endmodule

// File: tb/tb_x1_mem_arbiter.sv
// tb/tb_x1_mem_arbiter.sv - directed-vector bench for x1_mem_arbiter
module tb_x1_mem_arbiter;
    localparam int AW = 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;

    logic [AW-1:0] tr_addr [0:4095];
    logic          tr_we   [0:4095];
    logic [7:0]    mem     [0:65535];
    logic [7:0]    dl_bytes [0:3];

    x1_mem_arbiter_if #(.AW(AW)) bus ();

    x1_mem_arbiter #(.AW(AW), .DL_INDEX(8'h00)) dut (
        .clk_sys (clk),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // RAM model with one-cycle synchronous read
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
        bus.ram_dout <= mem[bus.ram_addr];
    end

    // Grant trace: entry n holds what the arbiter drove during cycle n
    always @(posedge clk) begin
        if (cyc < 4096) begin
            tr_addr[cyc] <= bus.ram_addr;
            tr_we[cyc]   <= bus.ram_we;
        end
        cyc <= cyc + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic seen;
        tick(); tick();
        vectors++;
        if ({bus.ioctl_wait, bus.dl_busy, bus.cpu_ack, bus.vid_valid, bus.ram_we} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b, want 00000",
                     {bus.ioctl_wait, bus.dl_busy, bus.cpu_ack, bus.vid_valid, bus.ram_we});
        end
        vectors++;
        if ({bus.ram_addr, bus.ram_din, bus.cpu_dout, bus.vid_dout} !== 40'h0) begin
            miscompares++;
            $display("FAIL reset_data: got %h, want 0",
                     {bus.ram_addr, bus.ram_din, bus.cpu_dout, bus.vid_dout});
        end
        reset = 1'b0;
        tick();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0010;
        #1;
        vectors++;
        if (bus.ram_addr !== 16'h0010) begin
            miscompares++;
            $display("FAIL reset_cpu_grant: got %h, want 0010", bus.ram_addr);
        end
        tick();
        reset = 1'b1;
        #1;
        vectors++;
        if ({bus.cpu_ack, bus.ioctl_wait, bus.ram_we} !== 3'b0 || bus.ram_addr !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_mid_read: got ack/wait/we %b addr %h, want 000 addr 0000",
                     {bus.cpu_ack, bus.ioctl_wait, bus.ram_we}, bus.ram_addr);
        end
        tick();
        bus.cpu_req = 1'b0;
        tick();
        reset = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            tick();
            if (bus.cpu_ack !== 1'b0) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_no_ack: got ack seen %b, want 0", seen);
        end
    endtask

    task automatic test_download();
        bus.ioctl_download = 1'b1; bus.ioctl_index = 8'h00;
        tick();
        vectors++;
        if (bus.dl_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL dl_busy_active: got %b, want 1", bus.dl_busy);
        end
        for (int i = 0; i < 4; i++) begin
            bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'(i); bus.ioctl_dout = dl_bytes[i];
            tick();
            bus.ioctl_wr = 1'b0;
            #1;
            vectors++;
            if (bus.ioctl_wait !== 1'b1 || bus.ram_we !== 1'b1 ||
                bus.ram_addr !== 16'(i) || bus.ram_din !== dl_bytes[i]) begin
                miscompares++;
                $display("FAIL dl_grant[%0d]: got wait %b we %b addr %h din %h, want 1 1 %h %h",
                         i, bus.ioctl_wait, bus.ram_we, bus.ram_addr, bus.ram_din, 16'(i), dl_bytes[i]);
            end
            tick();
            vectors++;
            if (bus.ioctl_wait !== 1'b0) begin
                miscompares++;
                $display("FAIL dl_wait_drop[%0d]: got %b, want 0", i, bus.ioctl_wait);
            end
        end
        bus.ioctl_download = 1'b0;
        tick(); tick();
        vectors++;
        if (bus.dl_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL dl_busy_idle: got %b, want 0", bus.dl_busy);
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (mem[i] !== dl_bytes[i]) begin
                miscompares++;
                $display("FAIL dl_ram[%0d]: got %h, want %h", i, mem[i], dl_bytes[i]);
            end
        end
    endtask

    task automatic test_out_of_range();
        bus.ioctl_download = 1'b1; bus.ioctl_index = 8'h00;
        tick();
        bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'h0010000; bus.ioctl_dout = 8'h77;
        tick();
        bus.ioctl_wr = 1'b0;
        #1;
        vectors++;
        if (bus.ioctl_wait !== 1'b0 || bus.ram_we !== 1'b0) begin
            miscompares++;
            $display("FAIL oor_grant: got wait %b we %b, want 0 0", bus.ioctl_wait, bus.ram_we);
        end
        tick();
        vectors++;
        if (bus.ioctl_wait !== 1'b0) begin
            miscompares++;
            $display("FAIL oor_wait: got %b, want 0", bus.ioctl_wait);
        end
        bus.ioctl_download = 1'b0;
        tick(); tick();
        vectors++;
        if (mem[0] !== 8'hA5) begin
            miscompares++;
            $display("FAIL oor_ram0: got %h, want a5", mem[0]);
        end
    endtask

    task automatic test_cpu();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h1234; bus.cpu_din = 8'h3C;
        #1;
        vectors++;
        if (bus.ram_we !== 1'b1 || bus.ram_addr !== 16'h1234 || bus.ram_din !== 8'h3C) begin
            miscompares++;
            $display("FAIL cpu_wr_grant: got we %b addr %h din %h, want 1 1234 3c",
                     bus.ram_we, bus.ram_addr, bus.ram_din);
        end
        tick();
        vectors++;
        if (bus.cpu_ack !== 1'b0 || bus.ram_we !== 1'b0) begin
            miscompares++;
            $display("FAIL cpu_wr_g1: got ack %b we %b, want 0 0", bus.cpu_ack, bus.ram_we);
        end
        tick();
        vectors++;
        if (bus.cpu_ack !== 1'b1) begin
            miscompares++;
            $display("FAIL cpu_wr_ack: got %b, want 1", bus.cpu_ack);
        end
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
        tick();
        vectors++;
        if (bus.cpu_ack !== 1'b0 || mem[16'h1234] !== 8'h3C) begin
            miscompares++;
            $display("FAIL cpu_wr_done: got ack %b ram %h, want 0 3c", bus.cpu_ack, mem[16'h1234]);
        end
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h1234;
        #1;
        vectors++;
        if (bus.ram_we !== 1'b0 || bus.ram_addr !== 16'h1234) begin
            miscompares++;
            $display("FAIL cpu_rd_grant: got we %b addr %h, want 0 1234", bus.ram_we, bus.ram_addr);
        end
        tick();
        vectors++;
        if (bus.cpu_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL cpu_rd_g1: got %b, want 0", bus.cpu_ack);
        end
        tick();
        vectors++;
        if (bus.cpu_ack !== 1'b1 || bus.cpu_dout !== 8'h3C) begin
            miscompares++;
            $display("FAIL cpu_rd_ack: got ack %b dout %h, want 1 3c", bus.cpu_ack, bus.cpu_dout);
        end
        bus.cpu_req = 1'b0;
        tick();
        vectors++;
        if (bus.cpu_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL cpu_rd_pulse: got %b, want 0", bus.cpu_ack);
        end
    endtask

    task automatic test_contention();
        int c0;
        tick(); tick();
        c0 = cyc;
        for (int k = 0; k < 6; k++) begin
            if (k == 3) begin
                vectors++;
                if (bus.vid_valid !== 1'b1 || bus.vid_dout !== 8'hFF) begin
                    miscompares++;
                    $display("FAIL cont_vid3: got valid %b dout %h, want 1 ff", bus.vid_valid, bus.vid_dout);
                end
            end
            if (k == 4) begin
                vectors++;
                if (bus.cpu_ack !== 1'b1 || bus.cpu_dout !== 8'h3C) begin
                    miscompares++;
                    $display("FAIL cont_cpu_ack: got ack %b dout %h, want 1 3c", bus.cpu_ack, bus.cpu_dout);
                end
                bus.cpu_req = 1'b0;
            end
            if (k == 5) begin
                vectors++;
                if (bus.vid_valid !== 1'b1 || bus.vid_dout !== 8'h5A) begin
                    miscompares++;
                    $display("FAIL cont_vid5: got valid %b dout %h, want 1 5a", bus.vid_valid, bus.vid_dout);
                end
            end
            bus.vid_req  = 1'b1;
            bus.vid_addr = (k < 4) ? 16'(3 - k) : 16'h1234;
            if (k == 1) begin
                bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h1234;
            end
            tick();
        end
        bus.vid_req = 1'b0;
        vectors++;
        if (bus.vid_valid !== 1'b1 || bus.vid_dout !== 8'hA5) begin
            miscompares++;
            $display("FAIL cont_vid6: got valid %b dout %h, want 1 a5", bus.vid_valid, bus.vid_dout);
        end
        repeat (4) tick();
        vectors++;
        if (tr_addr[c0+1] !== 16'h0003 || tr_addr[c0+2] !== 16'h1234 ||
            tr_addr[c0+3] !== 16'h0001 || tr_addr[c0+4] !== 16'h0000) begin
            miscompares++;
            $display("FAIL cont_order: got %h %h %h %h, want 0003 1234 0001 0000",
                     tr_addr[c0+1], tr_addr[c0+2], tr_addr[c0+3], tr_addr[c0+4]);
        end
    endtask

    task automatic test_collision();
        int c0;
        bus.ioctl_download = 1'b1; bus.ioctl_index = 8'h00;
        tick(); tick();
        c0 = cyc;
        bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'h4; bus.ioctl_dout = 8'h99;
        bus.vid_req  = 1'b1; bus.vid_addr   = 16'h0205;
        bus.cpu_req  = 1'b1; bus.cpu_we     = 1'b1; bus.cpu_addr = 16'h0300; bus.cpu_din = 8'h44;
        #1;
        vectors++;
        if (bus.ram_we !== 1'b0) begin
            miscompares++;
            $display("FAIL coll_g0_idle: got we %b, want 0", bus.ram_we);
        end
        tick();
        bus.ioctl_wr = 1'b0; bus.vid_req = 1'b0; bus.ioctl_download = 1'b0;
        vectors++;
        if (bus.dl_busy !== 1'b1 || bus.ioctl_wait !== 1'b1) begin
            miscompares++;
            $display("FAIL coll_g1_busy: got busy %b wait %b, want 1 1", bus.dl_busy, bus.ioctl_wait);
        end
        tick();
        vectors++;
        if (bus.dl_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL coll_g2_busy: got %b, want 1", bus.dl_busy);
        end
        tick();
        vectors++;
        if (bus.dl_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL coll_g3_busy: got %b, want 0", bus.dl_busy);
        end
        tick(); tick();
        vectors++;
        if (bus.cpu_ack !== 1'b1) begin
            miscompares++;
            $display("FAIL coll_cpu_ack: got %b, want 1", bus.cpu_ack);
        end
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
        tick(); tick();
        vectors++;
        if (tr_addr[c0+1] !== 16'h0205 || tr_we[c0+1] !== 1'b0 ||
            tr_addr[c0+2] !== 16'h0004 || tr_we[c0+2] !== 1'b1 ||
            tr_addr[c0+3] !== 16'h0300 || tr_we[c0+3] !== 1'b1) begin
            miscompares++;
            $display("FAIL coll_order: got %h/%b %h/%b %h/%b, want 0205/0 0004/1 0300/1",
                     tr_addr[c0+1], tr_we[c0+1], tr_addr[c0+2], tr_we[c0+2],
                     tr_addr[c0+3], tr_we[c0+3]);
        end
        vectors++;
        if (mem[4] !== 8'h99 || mem[16'h0300] !== 8'h44) begin
            miscompares++;
            $display("FAIL coll_ram: got %h %h, want 99 44", mem[4], mem[16'h0300]);
        end
    endtask

    initial begin
        dl_bytes[0] = 8'hA5; dl_bytes[1] = 8'h5A; dl_bytes[2] = 8'h00; dl_bytes[3] = 8'hFF;
        bus.ioctl_download = 1'b0; bus.ioctl_index = 8'h00; bus.ioctl_wr = 1'b0;
        bus.ioctl_addr = 25'h0; bus.ioctl_dout = 8'h00;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_din = 8'h00;
        bus.vid_req = 1'b0; bus.vid_addr = '0;
        #2 reset = 1'b1;
        test_reset();
        test_download();
        test_out_of_range();
        test_cpu();
        test_contention();
        test_collision();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
